// File: rtl/s_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// s_wr_arbiter_pkg
// Shared crossbar definitions used by the per-slave write/read arbiters:
//   - wr_arb_state_e : arbiter state encoding (IDLE/ADDR/DATA/RESP)
//   - AXI_LEN_W      : width of AXI AxLEN as carried through the crossbar
//   - XBAR_M_CNT     : default number of master interfaces
// No ports (package).
// -----------------------------------------------------------------------------
package s_wr_arbiter_pkg;

   localparam int AXI_LEN_W  = 4;
   localparam int XBAR_M_CNT = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } wr_arb_state_e;

endpackage

// File: rtl/s_wr_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// s_wr_arbiter_rr_picker
// Combinational round-robin picker, shared with the read-side arbiter.
// Ports:
//   req    in  N      request vector
//   ptr    in  IDX_W  index of the previous winner; search starts at ptr+1
//   onehot out N      one-hot winner (all zero when no request)
//   idx    out IDX_W  encoded winner
//   valid  out 1      at least one request present
// -----------------------------------------------------------------------------
module s_wr_arbiter_rr_picker #(
   parameter int N     = 6,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [N-1:0] above_s;
   logic [IDX_W:0] hi_pick_s;
   logic [IDX_W:0] lo_pick_s;
   logic [IDX_W:0] sel_s;

   // Returns {found, index of lowest set bit}.
   function automatic logic [IDX_W:0] lowest_set(input logic [N-1:0] vec);
      logic [IDX_W:0] r;
      r = {1'b0, {IDX_W{1'b0}}};
      for (int m = N - 1; m >= 0; m--) begin
         r = vec[m] ? {1'b1, IDX_W'(m)} : r;
      end
      return r;
   endfunction

   // Requesters strictly above ptr win first; otherwise wrap to the lowest requester.
   always_comb begin
      above_s = {N{1'b0}};
      onehot  = {N{1'b0}};
      for (int m = 0; m < N; m++) begin
         above_s[m] = (IDX_W'(m) > ptr);
      end
      hi_pick_s = lowest_set(req & above_s);
      lo_pick_s = lowest_set(req);
      sel_s     = hi_pick_s[IDX_W] ? hi_pick_s : lo_pick_s;
      valid     = sel_s[IDX_W];
      idx       = sel_s[IDX_W-1:0];
      for (int m = 0; m < N; m++) begin
         onehot[m] = valid & (idx == IDX_W'(m));
      end
   end

endmodule

// File: rtl/s_wr_arbiter.sv
// -----------------------------------------------------------------------------
// s_wr_arbiter
// Per-slave write-path arbiter (AXI clock domain). Picks one master whose AW
// head targets this slave, forwards its AW, locks W to that master for AWLEN+1
// beats, then holds the slave until the B response has been handed back.
// Optional build macro: S_WR_ARB_FIXED_PRIO_EN (lowest index wins, no rr_ptr).
// Ports:
//   AXI_CLK_i    in   clock
//   AXI_RST_i    in   synchronous active-high reset
//   aw_req_i     in   [M_CNT]   AW FIFO head valid and decoded to this slave
//   aw_len_i     in   [4*M_CNT] packed AWLEN per master
//   w_req_i      in   [M_CNT]   W FIFO non-empty and routed here
//   w_last_i     in   [M_CNT]   WLAST at each W FIFO head
//   s_awready_i  in   slave AW ready
//   s_wready_i   in   slave W ready
//   b_done_i     in   B response delivered to owner
//   s_awvalid_o  out  AW valid to slave
//   s_wvalid_o   out  W valid to slave
//   aw_grant_o   out  [M_CNT] one-hot AW FIFO pop
//   w_grant_o    out  [M_CNT] one-hot W FIFO pop
//   owner_o      out  [IDX_W] locked master (AW/W data mux select)
//   busy_o       out  arbiter not idle
//   wlast_err_o  out  pulse on WLAST/AWLEN disagreement for an accepted beat
// -----------------------------------------------------------------------------
module s_wr_arbiter
   import s_wr_arbiter_pkg::*;
#(
   parameter int M_CNT = XBAR_M_CNT,
   parameter int IDX_W = 3
) (
   input  logic                       AXI_CLK_i,
   input  logic                       AXI_RST_i,
   input  logic [M_CNT-1:0]           aw_req_i,
   input  logic [M_CNT*AXI_LEN_W-1:0] aw_len_i,
   input  logic [M_CNT-1:0]           w_req_i,
   input  logic [M_CNT-1:0]           w_last_i,
   input  logic                       s_awready_i,
   input  logic                       s_wready_i,
   input  logic                       b_done_i,
   output logic                       s_awvalid_o,
   output logic                       s_wvalid_o,
   output logic [M_CNT-1:0]           aw_grant_o,
   output logic [M_CNT-1:0]           w_grant_o,
   output logic [IDX_W-1:0]           owner_o,
   output logic                       busy_o,
   output logic                       wlast_err_o
);

   wr_arb_state_e          state_r;
   logic [IDX_W-1:0]       owner_r;
   logic [AXI_LEN_W-1:0]   len_r;
   logic [AXI_LEN_W-1:0]   beat_cnt_r;

   logic [M_CNT-1:0]       pick_onehot_s;
   logic [IDX_W-1:0]       pick_idx_s;
   logic                   pick_valid_s;
   logic [AXI_LEN_W-1:0]   pick_len_s;
   logic [M_CNT-1:0]       owner_onehot_s;
   logic                   owner_aw_req_s;
   logic                   owner_w_req_s;
   logic                   owner_w_last_s;
   logic                   aw_hs_s;
   logic                   w_hs_s;
   logic                   last_beat_s;

   function automatic logic [M_CNT-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [M_CNT-1:0] oh;
      oh = {M_CNT{1'b0}};
      for (int m = 0; m < M_CNT; m++) begin
         oh[m] = (idx == IDX_W'(m));
      end
      return oh;
   endfunction

`ifdef S_WR_ARB_FIXED_PRIO_EN
   // Fixed priority: the lowest requesting index wins.
   always_comb begin
      pick_valid_s = |aw_req_i;
      pick_idx_s   = {IDX_W{1'b0}};
      for (int m = M_CNT - 1; m >= 0; m--) begin
         pick_idx_s = aw_req_i[m] ? IDX_W'(m) : pick_idx_s;
      end
      pick_onehot_s = pick_valid_s ? idx_to_onehot(pick_idx_s) : {M_CNT{1'b0}};
   end
`else
   logic [IDX_W-1:0] rr_ptr_r;

   s_wr_arbiter_rr_picker #(
      .N     (M_CNT),
      .IDX_W (IDX_W)
   ) u_rr_picker (
      .req    (aw_req_i),
      .ptr    (rr_ptr_r),
      .onehot (pick_onehot_s),
      .idx    (pick_idx_s),
      .valid  (pick_valid_s)
   );
`endif

   // AWLEN of the winning master, selected by the one-hot pick.
   always_comb begin
      pick_len_s = {AXI_LEN_W{1'b0}};
      for (int m = 0; m < M_CNT; m++) begin
         pick_len_s = pick_len_s | (aw_len_i[m*AXI_LEN_W +: AXI_LEN_W] & {AXI_LEN_W{pick_onehot_s[m]}});
      end
   end

   assign owner_onehot_s = idx_to_onehot(owner_r);
   assign owner_aw_req_s = |(aw_req_i & owner_onehot_s);
   assign owner_w_req_s  = |(w_req_i  & owner_onehot_s);
   assign owner_w_last_s = |(w_last_i & owner_onehot_s);
   assign last_beat_s    = (beat_cnt_r == len_r);

   // Channel valids, handshakes and pop strobes; strobes are forced low while reset is held.
   always_comb begin
      s_awvalid_o = 1'b0;
      s_wvalid_o  = 1'b0;
      case (state_r)
         ST_ADDR: s_awvalid_o = ~AXI_RST_i & owner_aw_req_s;
         ST_DATA: s_wvalid_o  = ~AXI_RST_i & owner_w_req_s;
         default: s_awvalid_o = 1'b0;
      endcase
      aw_hs_s     = s_awvalid_o & s_awready_i;
      w_hs_s      = s_wvalid_o & s_wready_i;
      aw_grant_o  = aw_hs_s ? owner_onehot_s : {M_CNT{1'b0}};
      w_grant_o   = w_hs_s ? owner_onehot_s : {M_CNT{1'b0}};
      // AWLEN decides the burst end; WLAST is only cross-checked.
      wlast_err_o = w_hs_s & (owner_w_last_s != last_beat_s);
   end

   assign owner_o = owner_r;
   assign busy_o  = (state_r != ST_IDLE);

   // Arbitration FSM: owner lock, burst length capture and beat counting.
   always_ff @(posedge AXI_CLK_i) begin
      if (AXI_RST_i) begin
         state_r    <= ST_IDLE;
         owner_r    <= {IDX_W{1'b0}};
         len_r      <= {AXI_LEN_W{1'b0}};
         beat_cnt_r <= {AXI_LEN_W{1'b0}};
`ifndef S_WR_ARB_FIXED_PRIO_EN
         rr_ptr_r   <= IDX_W'(M_CNT - 1);
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_valid_s) begin
                  owner_r    <= pick_idx_s;
                  len_r      <= pick_len_s;
                  beat_cnt_r <= {AXI_LEN_W{1'b0}};
                  state_r    <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (aw_hs_s) begin
                  state_r <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_hs_s) begin
                  if (last_beat_s) begin
                     beat_cnt_r <= {AXI_LEN_W{1'b0}};
                     state_r    <= ST_RESP;
                  end else begin
                     beat_cnt_r <= beat_cnt_r + 4'd1;
                  end
               end
            end
            ST_RESP: begin
               if (b_done_i) begin
`ifndef S_WR_ARB_FIXED_PRIO_EN
                  rr_ptr_r <= owner_r;
`endif
                  state_r  <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_s_wr_arbiter.sv
module tb_s_wr_arbiter;

   localparam int M_CNT = 6;
   localparam int IDX_W = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  aw_req = 6'd0;
   logic [23:0] aw_len = 24'd0;
   logic [5:0]  w_req = 6'd0;
   logic [5:0]  w_last = 6'd0;
   logic        awready = 1'b1;
   logic        wready = 1'b1;
   logic        b_done = 1'b0;
   logic        s_awvalid, s_wvalid, busy, wlast_err;
   logic [5:0]  aw_grant, w_grant;
   logic [2:0]  owner;

   int total = 0;
   int bad = 0;
   logic mon_en = 1'b0;

   typedef struct packed {
      logic [5:0] awg;
      logic [5:0] wg;
      logic       err;
      logic [2:0] own;
   } ev_t;
   ev_t sb_q[$];
   ev_t mon_got, mon_exp;

   typedef struct {
      logic rst; logic [5:0] awr; logic [5:0] wr; logic [5:0] wl;
      logic awrdy; logic wrdy; logic bd;
      logic [18:0] exp;   // {awvalid, wvalid, aw_grant, w_grant, owner, busy, err}
   } vec_t;
   vec_t vecs[$];

   s_wr_arbiter #(.M_CNT(M_CNT), .IDX_W(IDX_W)) dut (
      .AXI_CLK_i(clk), .AXI_RST_i(rst), .aw_req_i(aw_req), .aw_len_i(aw_len),
      .w_req_i(w_req), .w_last_i(w_last), .s_awready_i(awready), .s_wready_i(wready),
      .b_done_i(b_done), .s_awvalid_o(s_awvalid), .s_wvalid_o(s_wvalid),
      .aw_grant_o(aw_grant), .w_grant_o(w_grant), .owner_o(owner), .busy_o(busy),
      .wlast_err_o(wlast_err)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] oh(input int m);
      logic [5:0] v;
      v = 6'd0;
      v[m] = 1'b1;
      return v;
   endfunction

   function automatic vec_t row(input logic r, input logic [5:0] awr, input logic [5:0] wr, input logic [5:0] wl,
                                input logic awrdy, input logic bd, input logic e_awv, input logic e_wv,
                                input logic [5:0] e_awg, input logic [5:0] e_wg, input logic [2:0] e_own,
                                input logic e_busy, input logic e_err);
      vec_t v;
      v.rst = r; v.awr = awr; v.wr = wr; v.wl = wl; v.awrdy = awrdy; v.wrdy = 1'b1; v.bd = bd;
      v.exp = {e_awv, e_wv, e_awg, e_wg, e_own, e_busy, e_err};
      return v;
   endfunction

   task automatic push_aw(input int m);
      sb_q.push_back('{awg: oh(m), wg: 6'd0, err: 1'b0, own: 3'(m)});
   endtask

   task automatic push_w(input int m, input logic e);
      sb_q.push_back('{awg: 6'd0, wg: oh(m), err: e, own: 3'(m)});
   endtask

   task automatic drive(input logic r, input logic [5:0] awr, input logic [5:0] wr, input logic [5:0] wl,
                        input logic awrdy, input logic wrdy, input logic bd);
      @(negedge clk);
      rst = r; aw_req = awr; w_req = wr; w_last = wl; awready = awrdy; wready = wrdy; b_done = bd;
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every grant or error pulse must match the next queued expectation.
   always @(negedge clk) begin
      #2;
      if (mon_en && (aw_grant != 6'd0 || w_grant != 6'd0 || wlast_err)) begin
         mon_got = '{awg: aw_grant, wg: w_grant, err: wlast_err, own: owner};
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected actual=%h required=none at %0t", mon_got, $time);
         end else begin
            mon_exp = sb_q.pop_front();
            if (mon_got !== mon_exp) begin
               bad++;
               $display("FAIL sb_event actual=%h required=%h at %0t", mon_got, mon_exp, $time);
            end
         end
      end
   end

   initial begin
      int nb;
      bit [9:0] wr_pat;
      bit [9:0] wq_pat;
      logic wq;

      // ---------------- table-driven section ----------------
      aw_len = 24'h002300;   // m2 len 3, m3 len 2, m5 len 0
      vecs.push_back(row(1'b1, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 3'd0, 1'b0, 1'b0));
      vecs.push_back(row(1'b0, 6'h04, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 3'd0, 1'b0, 1'b0));
      vecs.push_back(row(1'b0, 6'h04, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 6'h04, 6'h00, 3'd2, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h04, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 6'h04, 3'd2, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h04, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 6'h04, 3'd2, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h04, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 6'h04, 3'd2, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h04, 6'h04, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 6'h04, 3'd2, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 3'd2, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 3'd2, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 3'd2, 1'b0, 1'b0));
      vecs.push_back(row(1'b0, 6'h08, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 3'd2, 1'b0, 1'b0));
      vecs.push_back(row(1'b0, 6'h08, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 6'h08, 6'h00, 3'd3, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h08, 6'h08, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 6'h08, 3'd3, 1'b1, 1'b1));
      vecs.push_back(row(1'b0, 6'h00, 6'h08, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 6'h08, 3'd3, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h08, 6'h08, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 6'h08, 3'd3, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 3'd3, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 3'd3, 1'b0, 1'b0));
      vecs.push_back(row(1'b0, 6'h20, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 3'd3, 1'b0, 1'b0));
      vecs.push_back(row(1'b0, 6'h20, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 6'h00, 3'd5, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h20, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 6'h20, 6'h00, 3'd5, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h20, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 6'h20, 3'd5, 1'b1, 1'b1));
      vecs.push_back(row(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 3'd5, 1'b1, 1'b0));
      vecs.push_back(row(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 3'd5, 1'b0, 1'b0));

      repeat (2) @(posedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].awr, vecs[i].wr, vecs[i].wl, vecs[i].awrdy, vecs[i].wrdy, vecs[i].bd);
         chk($sformatf("vec%0d", i),
             {13'd0, s_awvalid, s_wvalid, aw_grant, w_grant, owner, busy, wlast_err}, {13'd0, vecs[i].exp});
      end

      // ---------------- scoreboard sequences ----------------
      mon_en = 1'b1;

      // Round-robin fairness: everyone requests, len 0 bursts; last owner was 5.
      aw_len = 24'h000000;
      for (int k = 0; k < 7; k++) begin
         push_aw(k % 6);
         push_w(k % 6, 1'b0);
         drive(1'b0, 6'h3f, 6'h3f, 6'h3f, 1'b1, 1'b1, 1'b0);
         drive(1'b0, 6'h3f, 6'h3f, 6'h3f, 1'b1, 1'b1, 1'b0);
         drive(1'b0, 6'h3f, 6'h3f, 6'h3f, 1'b1, 1'b1, 1'b0);
         drive(1'b0, 6'h3f, 6'h3f, 6'h3f, 1'b1, 1'b1, 1'b1);
      end

      // Backpressure: master 4, len 3, wready toggles and w_req stalls two cycles.
      aw_len = 24'h030000;
      wr_pat = 10'b11_0101_0101;
      wq_pat = 10'b11_1111_0011;
      push_aw(4);
      drive(1'b0, 6'h10, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h10, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      nb = 0;
      for (int i = 0; i < 10; i++) begin
         wq = wq_pat[i];
         drive(1'b0, 6'h00, wq ? 6'h10 : 6'h00, (nb == 3) ? 6'h10 : 6'h00, 1'b1, wr_pat[i], (i == 9) ? 1'b1 : 1'b0);
         chk($sformatf("bp_wvalid%0d", i), {31'd0, s_wvalid}, {31'd0, (nb < 4) ? wq : 1'b0});
         if (nb < 4 && wq && wr_pat[i]) begin
            push_w(4, 1'b0);
            nb++;
         end
      end
      drive(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      chk("bp_idle_busy", {31'd0, busy}, 32'd0);

      // Lock: master 0 requests during master 1's burst; waits until b_done.
      aw_len = 24'h000010;
      push_aw(1); push_w(1, 1'b0); push_w(1, 1'b0); push_aw(0); push_w(0, 1'b0);
      drive(1'b0, 6'h02, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h02, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h01, 6'h02, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h01, 6'h02, 6'h02, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 6'h01, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
         chk($sformatf("lock_hold%0d", i), {24'd0, s_awvalid, busy, aw_grant}, {24'd0, 1'b0, 1'b1, 6'h00});
      end
      drive(1'b0, 6'h01, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 6'h01, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h01, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      chk("lock_owner0", {29'd0, owner}, 32'd0);
      drive(1'b0, 6'h00, 6'h01, 6'h01, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1);

      // Reset in DATA after 2 of 4 beats of master 3; then rr pointer must be back at 5.
      aw_len = 24'h003000;
      push_aw(3); push_w(3, 1'b0); push_w(3, 1'b0); push_aw(0); push_w(0, 1'b0);
      drive(1'b0, 6'h08, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h08, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h00, 6'h08, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h00, 6'h08, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h3f, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      chk("rst_idle", {18'd0, busy, s_awvalid, s_wvalid, aw_grant, w_grant},
          {18'd0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00});
      drive(1'b0, 6'h3f, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      chk("rst_rr_owner", {29'd0, owner}, 32'd0);
      drive(1'b0, 6'h00, 6'h01, 6'h01, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1);

      // Longest burst: master 5, len 15 -> 16 beats.
      aw_len = 24'hF00000;
      push_aw(5);
      for (int i = 0; i < 16; i++) push_w(5, 1'b0);
      drive(1'b0, 6'h20, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 6'h20, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 6'h00, 6'h20, (i == 15) ? 6'h20 : 6'h00, 1'b1, 1'b1, 1'b0);
      end
      drive(1'b0, 6'h00, 6'h20, 6'h00, 1'b1, 1'b1, 1'b0);
      chk("len15_resp", {30'd0, busy, s_wvalid}, {30'd0, 1'b1, 1'b0});
      drive(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      chk("len15_idle", {31'd0, busy}, 32'd0);

      drive(1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0);
      #3;
      chk("sb_leftover", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/s_wr_arbiter.md
Name: s_wr_arbiter

Overview:
- Per-slave write-path arbiter in the crossbar's AXI clock domain.
- Chooses one master interface at a time from those whose AW FIFO heads target this slave, issues that master's AW to the slave, then locks the W channel to the same master until the burst completes.
- Holds the slave until the B response is consumed.
- Produces the one-hot pop strobes (aw_in_grant / w_in_grant bits) and the data-mux select for this slave.

Parameters:
- M_CNT, 6, number of master interfaces competing for this slave.
- IDX_W, 3, width of an encoded master index; must satisfy 2^IDX_W >= M_CNT.

Ports:
- AXI_CLK_i  in  1  crossbar clock.
- AXI_RST_i  in  1  synchronous, active-high reset.
- aw_req_i  in  M_CNT  bit m: master m AW FIFO head valid and decoded to this slave.
- aw_len_i  in  M_CNT*4  packed AWLEN of each master's AW head; master m at [4m+3:4m].
- w_req_i  in  M_CNT  bit m: master m W FIFO non-empty and routed to this slave.
- w_last_i  in  M_CNT  WLAST of each master's W FIFO head.
- s_awready_i  in  1  slave accepts AW.
- s_wready_i  in  1  slave accepts W beat.
- b_done_i  in  1  this slave's B response has been pushed into the owner's B FIFO.
- s_awvalid_o  out  1  AW valid toward the slave.
- s_wvalid_o  out  1  W valid toward the slave.
- aw_grant_o  out  M_CNT  one-hot AW FIFO pop strobe.
- w_grant_o  out  M_CNT  one-hot W FIFO pop strobe.
- owner_o  out  IDX_W  encoded index of the locked master; selects the AW/W data mux.
- busy_o  out  1  arbiter is not in IDLE.
- wlast_err_o  out  1  one-cycle pulse on a WLAST/AWLEN mismatch.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Clock and reset ports are AXI_CLK_i / AXI_RST_i.
- Reset values:
  - state = IDLE, rr_ptr = M_CNT-1, owner = 0, beat_cnt = 0.
  - All outputs 0.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any aw_req_i bit is set, pick the winner round-robin: the first set bit searching from rr_ptr+1 upward, wrapping modulo M_CNT.
  - Register the winner in owner, latch its aw_len_i into len_q, clear beat_cnt, go to ADDR.
  - No outputs are asserted in IDLE, so arbitration costs one cycle.
- ADDR:
  - s_awvalid_o = aw_req_i[owner]. If the owner's request drops, the arbiter waits in ADDR; it never re-arbitrates once locked.
  - aw_grant_o[owner] = s_awvalid_o & s_awready_i, combinational and single-cycle. On that handshake, go to DATA.
- DATA:
  - s_wvalid_o = w_req_i[owner].
  - w_grant_o[owner] = s_wvalid_o & s_wready_i. Each accepted beat increments beat_cnt (4-bit).
  - The burst ends on the accepted beat where beat_cnt == len_q. Then go to RESP.
  - wlast_err_o pulses if w_last_i[owner] != (beat_cnt == len_q) on an accepted beat. An early WLAST does not end the burst; AWLEN is authoritative.
- RESP:
  - Wait for b_done_i. Then set rr_ptr = owner and go to IDLE.
  - b_done_i in any other state is ignored.
- busy_o = (state != IDLE).
- owner_o is stable from ADDR through RESP.
- At most one bit of aw_grant_o / w_grant_o is set, and never both channels in the same cycle.
- Reset mid-burst: return to IDLE immediately with all strobes low. FIFO flushing is the reset's responsibility elsewhere.
- AWLEN = 0 gives a single-beat burst. len 15 gives 16 beats with no counter overflow.

Optional Feature:
- Macro S_WR_ARB_FIXED_PRIO_EN.
- Defined: IDLE grants the lowest-index requesting master (fixed priority), and rr_ptr is not maintained.
- Undefined (default): round-robin as described above.

Decomposition:
- Shared crossbar package holds:
  - the state enum typedef (IDLE/ADDR/DATA/RESP);
  - the AXI len width constant (4);
  - the default master count (6).
- Natural sub-module: rr_picker. Combinational: request vector + pointer -> one-hot + encoded winner. It is reused by the read-side arbiter.
- Under S_WR_ARB_FIXED_PRIO_EN, rr_picker is bypassed by a priority encoder.

Test Plan:
- Single master: aw_req=6'b000100, len=3, slave always ready -> owner_o=2; aw_grant pulse 1 cycle after the request; 4 w_grant[2] pulses with WLAST on the 4th; RESP held until b_done; busy_o low the cycle after.
- Round-robin fairness: aw_req=6'b111111 held, bursts of len 0 -> owners 0,1,2,3,4,5,0 in order; no master granted twice in a row.
- Backpressure: s_wready_i toggling 1,0,1,0 with w_req[owner] stalling 2 cycles -> w_grant only on cycles with both high; beat_cnt is not advanced by stalls.
- Lock: during master 1's DATA, master 0 raises aw_req -> no aw_grant[0] until master 1's b_done; then master 0 wins.
- Mismatch: len=2, WLAST asserted on beat 1 -> wlast_err_o pulse on beat 1; burst continues to 3 beats; no error on beat 3 when WLAST is correct.
- Reset in DATA after 2 of 4 beats -> next cycle state IDLE, all grants 0, busy_o 0, rr_ptr = M_CNT-1.
